// File: rtl/reg_file_snap_rd_if.sv
// ---------------------------------------------------------------------------
// reg_file_snap_rd_if
//
// Snapshot delivery channel between the register-file snapshot reader
// (master) and whatever consumes the packed snapshot word (slave).
//
// Signals:
//   snap_valid_out  master -> slave  snap_out / torn_out (/ seq_out) are valid
//   snap_ready_in   slave  -> master consumer accepts the word this cycle
//   snap_out        master -> slave  packed snapshot, entry i at [16i+15:16i]
//   torn_out        master -> slave  word may mix data from before/after writes
//   seq_out         master -> slave  words accepted before this one, mod 256
//                                    (present only when SNAP_SEQ_EN is defined)
//
// Handshake: a word transfers on every rising clock edge where snap_valid_out
// and snap_ready_in are both high. Once snap_valid_out rises, it and the
// qualified data stay unchanged until that transfer edge. snap_ready_in may
// toggle freely and has no effect while snap_valid_out is low.
//
// Optional build macro: SNAP_SEQ_EN (adds seq_out).
// ---------------------------------------------------------------------------
interface reg_file_snap_rd_if #(
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 2
);
  logic                        snap_valid_out;
  logic                        snap_ready_in;
  logic [ENTRIES*DATA_W-1:0]   snap_out;
  logic                        torn_out;
`ifdef SNAP_SEQ_EN
  logic [7:0]                  seq_out;

  modport master (
    output snap_valid_out,
    output snap_out,
    output torn_out,
    output seq_out,
    input  snap_ready_in
  );

  modport slave (
    input  snap_valid_out,
    input  snap_out,
    input  torn_out,
    input  seq_out,
    output snap_ready_in
  );
`else
  modport master (
    output snap_valid_out,
    output snap_out,
    output torn_out,
    input  snap_ready_in
  );

  modport slave (
    input  snap_valid_out,
    input  snap_out,
    input  torn_out,
    output snap_ready_in
  );
`endif
endinterface

// File: rtl/reg_file_snap_rd.sv
// ---------------------------------------------------------------------------
// reg_file_snap_rd
//
// Sequential snapshot reader for a small register file. On request it walks
// the file's read address over every entry (one entry per cycle, sampling the
// combinational read data), packs the entries into one word in write-lane
// order and offers that word over a valid/ready channel. A write seen during
// the walk makes the snapshot suspect, so the walk restarts, up to MAX_RETRY
// times; after that the word is delivered flagged as torn.
//
// Ports:
//   clock       in   single clock, all state changes on posedge
//   reset       in   synchronous active-high reset
//   start_in    in   request one snapshot (pulse or level)
//   wr_en_in    in   copy of the register file write enable
//   rdata_in    in   register file read data, combinational from raddr_out
//   raddr_out   out  register file read address (registered)
//   busy_out    out  high whenever the reader is not idle
//   dbg_state   out  current FSM state (0 idle, 1 sweep, 2 hold)
//   snap        master side of reg_file_snap_rd_if (valid/ready word channel)
//
// Optional build macro: SNAP_SEQ_EN adds snap.seq_out, an 8-bit count of
// accepted words that wraps 255 -> 0.
//
// Timing of one clean snapshot (ENTRIES=2), start sampled at edge N:
//   N    : enter SWEEP, raddr=0
//   N+1  : capture entry 0, raddr=1
//   N+2  : capture entry 1, raddr wraps to 0
//   N+3  : commit lanes to snap_out, raise snap_valid_out (HOLD)
// A write sampled on a capture edge marks the sweep dirty; the next edge
// restarts the sweep instead of capturing/committing, provided retries remain.
// ---------------------------------------------------------------------------
module reg_file_snap_rd #(
  parameter int DATA_W    = 16,
  parameter int ENTRIES   = 2,
  parameter int ADDR_W    = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in,
  input  logic              wr_en_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [ADDR_W-1:0] raddr_out,
  output logic              busy_out,
  output logic [1:0]        dbg_state,
  reg_file_snap_rd_if.master snap
);

  // One extra index bit so "all entries captured" is its own value.
  localparam int                 IDX_W     = ADDR_W + 1;
  localparam int                 RETRY_W   = 4;
  localparam logic [IDX_W-1:0]   DONE_IDX  = IDX_W'(ENTRIES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]          index_q;
  logic [ADDR_W-1:0]         raddr_q;
  logic [RETRY_W-1:0]        retry_q;
  logic                      dirty_q;
  logic [DATA_W-1:0]         lane_q [ENTRIES];
  logic [ENTRIES*DATA_W-1:0] snap_q;
  logic                      valid_q;
  logic                      torn_q;

  logic [ENTRIES*DATA_W-1:0] lanes_packed;
  logic                      sweep_done;
  logic                      can_retry;
  logic                      accept;

  // FSM strobes consumed by the datapath register block.
  logic                      begin_sweep;
  logic                      restart;
  logic                      capture;
  logic                      commit;

  assign sweep_done = (index_q == DONE_IDX);
  assign can_retry  = (retry_q < RETRY_MAX);
  assign accept     = valid_q & snap.snap_ready_in;

  // Lane i of the output word is entry i of the register file.
  always_comb begin
    lanes_packed = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lanes_packed[i*DATA_W +: DATA_W] = lane_q[i];
    end
  end

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and datapath strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    begin_sweep = 1'b0;
    restart     = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d     = S_SWEEP;
          begin_sweep = 1'b1;
        end
      end

      S_SWEEP: begin
        // A dirty sweep is abandoned at the first edge after the write was
        // seen, whether that edge would have captured or committed. Once the
        // retry budget is spent the dirty flag just rides along to torn.
        if (dirty_q && can_retry) begin
          restart = 1'b1;
        end else if (sweep_done) begin
          commit  = 1'b1;
          state_d = S_HOLD;
        end else begin
          capture = 1'b1;
        end
      end

      S_HOLD: begin
        // start_in only counts in the transfer cycle; it chains straight
        // into a new sweep without passing through IDLE.
        if (accept) begin
          if (start_in) begin
            state_d     = S_SWEEP;
            begin_sweep = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      index_q <= '0;
      raddr_q <= '0;
      retry_q <= '0;
      dirty_q <= 1'b0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      torn_q  <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      // Fresh sweep or restart: rewind the walk. A write sampled on this
      // edge has already landed before the new walk reads anything, so it
      // does not carry into the new sweep.
      if (begin_sweep || restart) begin
        index_q <= '0;
        raddr_q <= '0;
        dirty_q <= 1'b0;
      end

      if (begin_sweep) begin
        retry_q <= '0;
      end

      if (restart) begin
        retry_q <= retry_q + RETRY_W'(1);
      end

      if (capture) begin
        lane_q[index_q[ADDR_W-1:0]] <= rdata_in;
        index_q                     <= index_q + IDX_W'(1);
        raddr_q                     <= raddr_q + ADDR_W'(1);
        dirty_q                     <= dirty_q | wr_en_in;
      end

      // Reaching commit with dirty set is only possible after the retry
      // budget ran out, so dirty is exactly the torn qualifier.
      if (commit) begin
        snap_q  <= lanes_packed;
        torn_q  <= dirty_q;
        valid_q <= 1'b1;
        index_q <= '0;
        raddr_q <= '0;
      end

      if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SNAP_SEQ_EN
  // Count of accepted words; presented alongside the next word.
  logic [7:0] seq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q <= '0;
    end else if (accept) begin
      seq_q <= seq_q + 8'd1;
    end
  end

  assign snap.seq_out = seq_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign raddr_out           = raddr_q;
  assign busy_out            = (state_q != S_IDLE);
  assign dbg_state           = state_q;
  assign snap.snap_valid_out = valid_q;
  assign snap.snap_out       = snap_q;
  assign snap.torn_out       = torn_q;

endmodule

// File: tb/tb_reg_file_snap_rd.sv
// ---------------------------------------------------------------------------
// tb_reg_file_snap_rd
//
// Bench for reg_file_snap_rd with a behavioural 2-entry register file. The
// register file writes both lanes at once from wr_word when wr_en_in is high
// and returns rf[raddr_out] combinationally. Expected {torn, word} results
// are queued when a snapshot is requested and popped at the transfer cycle.
// ---------------------------------------------------------------------------
module tb_reg_file_snap_rd;

  localparam int DATA_W  = 16;
  localparam int ENTRIES = 2;
  localparam int W       = ENTRIES * DATA_W + 1;
  localparam int BOUND   = 60;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic              clock = 1'b0;
  logic              reset;
  logic              start_in;
  logic              wr_en_in;
  logic [DATA_W-1:0] rdata_in;
  logic [0:0]        raddr_out;
  logic              busy_out;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] rf [ENTRIES];
  logic [31:0]       wr_word;

  always #5 clock = ~clock;

  reg_file_snap_rd_if #(.DATA_W(DATA_W), .ENTRIES(ENTRIES)) snap_if ();

  reg_file_snap_rd #(
    .DATA_W   (DATA_W),
    .ENTRIES  (ENTRIES),
    .ADDR_W   (1),
    .MAX_RETRY(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start_in (start_in),
    .wr_en_in (wr_en_in),
    .rdata_in (rdata_in),
    .raddr_out(raddr_out),
    .busy_out (busy_out),
    .dbg_state(dbg_state),
    .snap     (snap_if)
  );

  assign rdata_in = rf[raddr_out];

  always @(posedge clock) begin
    if (wr_en_in) begin
      rf[0] <= wr_word[15:0];
      rf[1] <= wr_word[31:16];
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard state and counters
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_assert = 0;
  int           n_fail   = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Driver tasks (no checking)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_rf(input logic [31:0] word);
    wr_word  = word;
    wr_en_in = 1'b1;
    tick();
    wr_en_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (snap_if.snap_valid_out !== 1'b1 && lat < BOUND) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_exp(output logic [W-1:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 'x;
  endtask

  // -------------------------------------------------------------------------
  // Scenario tasks
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b1;
    start_in = 1'b0;
    wr_en_in = 1'b0;
    wr_word  = '0;
    snap_if.snap_ready_in = 1'b0;
    tick();
    tick();
    n_assert++;
    if ({raddr_out, busy_out, snap_if.snap_valid_out, snap_if.torn_out, snap_if.snap_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got raddr=%0h busy=%0b valid=%0b torn=%0b snap=%h, want all 0",
               raddr_out, busy_out, snap_if.snap_valid_out, snap_if.torn_out, snap_if.snap_out);
    end
    n_assert++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
`ifdef SNAP_SEQ_EN
    n_assert++;
    if (snap_if.seq_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_seq: got %0d want 0", snap_if.seq_out);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    logic [W-1:0] e;
    logic [0:0]   r0;
    logic [0:0]   r1;
    int           lat;
    load_rf(32'hABCD_1234);
    snap_if.snap_ready_in = 1'b1;
    exp_q.push_back({1'b0, 32'hABCD_1234});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    r0 = raddr_out;
    tick();
    r1 = raddr_out;
    wait_valid(lat);
    lat = lat + 1;
    n_assert++;
    if (r0 !== 1'b0 || r1 !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_raddr_seq: got %0h,%0h want 0,1", r0, r1);
    end
    n_assert++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL clean_latency: got %0d want 3", lat);
    end
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL clean_word: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
    n_assert++;
    if (snap_if.snap_valid_out !== 1'b0 || busy_out !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL clean_after_accept: got valid=%0b busy=%0b state=%0d want 0,0,0",
               snap_if.snap_valid_out, busy_out, dbg_state);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    int           lat;
    load_rf(32'h0F0F_F0F0);
    snap_if.snap_ready_in = 1'b0;
    exp_q.push_back({1'b0, 32'h0F0F_F0F0});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(lat);
    n_assert++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      start_in = (i == 1 || i == 3);
      tick();
      n_assert++;
      if (snap_if.snap_valid_out !== 1'b1 || {snap_if.torn_out, snap_if.snap_out} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL bp_stable_%0d: got valid=%0b word=%h want 1,%h",
                 i, snap_if.snap_valid_out, {snap_if.torn_out, snap_if.snap_out}, exp_q[0]);
      end
    end
    start_in = 1'b0;
    snap_if.snap_ready_in = 1'b1;
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL bp_word: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
    n_assert++;
    if (snap_if.snap_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%0b busy=%0b want 0,0", snap_if.snap_valid_out, busy_out);
    end
    tick();
    tick();
    tick();
    n_assert++;
    if (snap_if.snap_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_start_not_queued: got valid=%0b busy=%0b want 0,0",
               snap_if.snap_valid_out, busy_out);
    end
    n_assert++;
    if (snap_if.snap_out !== 32'h0F0F_F0F0) begin
      n_fail++;
      $display("FAIL bp_idle_hold: got %h want 0f0ff0f0", snap_if.snap_out);
    end
  endtask

  task automatic test_write_first();
    logic [W-1:0] e;
    int           lat;
    load_rf(32'h1111_2222);
    snap_if.snap_ready_in = 1'b1;
    exp_q.push_back({1'b0, 32'h5555_6666});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wr_word  = 32'h5555_6666;
    wr_en_in = 1'b1;
    tick();
    wr_en_in = 1'b0;
    wait_valid(lat);
    lat = lat + 1;
    n_assert++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL wr_first_latency: got %0d want 5", lat);
    end
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL wr_first_word: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
  endtask

  task automatic test_write_last();
    logic [W-1:0] e;
    int           lat;
    load_rf(32'h3333_4444);
    snap_if.snap_ready_in = 1'b1;
    exp_q.push_back({1'b0, 32'h7777_8888});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    wr_word  = 32'h7777_8888;
    wr_en_in = 1'b1;
    tick();
    wr_en_in = 1'b0;
    wait_valid(lat);
    lat = lat + 2;
    n_assert++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL wr_last_latency: got %0d want 6", lat);
    end
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL wr_last_word: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
  endtask

  task automatic test_retry_exhaust();
    logic [W-1:0] e;
    int           lat;
    load_rf(32'h0000_0001);
    snap_if.snap_ready_in = 1'b1;
    exp_q.push_back({1'b1, 32'hCAFE_F00D});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wr_word  = 32'hCAFE_F00D;
    wr_en_in = 1'b1;
    wait_valid(lat);
    wr_en_in = 1'b0;
    // 3 restarts of 2 cycles each on top of the 3-cycle clean sweep.
    n_assert++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL exhaust_latency: got %0d want 9", lat);
    end
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL exhaust_word: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int           lat;
    load_rf(32'h0123_4567);
    snap_if.snap_ready_in = 1'b1;
    exp_q.push_back({1'b0, 32'h0123_4567});
    exp_q.push_back({1'b0, 32'h89AB_CDEF});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(lat);
    n_assert++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL b2b_latency_1: got %0d want 3", lat);
    end
    // Write while holding: lands before the chained sweep reads anything.
    start_in = 1'b1;
    wr_word  = 32'h89AB_CDEF;
    wr_en_in = 1'b1;
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL b2b_word_1: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
    start_in = 1'b0;
    wr_en_in = 1'b0;
    n_assert++;
    if (snap_if.snap_valid_out !== 1'b0 || busy_out !== 1'b1 || dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_direct_sweep: got valid=%0b busy=%0b state=%0d want 0,1,1",
               snap_if.snap_valid_out, busy_out, dbg_state);
    end
    wait_valid(lat);
    n_assert++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL b2b_latency_2: got %0d want 3", lat);
    end
    pop_exp(e);
    n_assert++;
    if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
      n_fail++;
      $display("FAIL b2b_word_2: got %h want %h", {snap_if.torn_out, snap_if.snap_out}, e);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    load_rf(32'h1357_9BDF);
    snap_if.snap_ready_in = 1'b0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_assert++;
    if ({raddr_out, busy_out, snap_if.snap_valid_out, snap_if.torn_out, snap_if.snap_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_sweep: got raddr=%0h busy=%0b valid=%0b torn=%0b snap=%h, want all 0",
               raddr_out, busy_out, snap_if.snap_valid_out, snap_if.torn_out, snap_if.snap_out);
    end
`ifdef SNAP_SEQ_EN
    n_assert++;
    if (snap_if.seq_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_sweep_seq: got %0d want 0", snap_if.seq_out);
    end
`endif
    exp_q.push_back({1'b0, 32'h1357_9BDF});
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(lat);
    n_assert++;
    if (lat !== 3 || {snap_if.torn_out, snap_if.snap_out} !== exp_q[0]) begin
      n_fail++;
      $display("FAIL reset_hold_setup: got lat=%0d word=%h want 3,%h",
               lat, {snap_if.torn_out, snap_if.snap_out}, exp_q[0]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    n_assert++;
    if ({raddr_out, busy_out, snap_if.snap_valid_out, snap_if.torn_out, snap_if.snap_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got raddr=%0h busy=%0b valid=%0b torn=%0b snap=%h, want all 0",
               raddr_out, busy_out, snap_if.snap_valid_out, snap_if.torn_out, snap_if.snap_out);
    end
    tick();
    n_assert++;
    if (snap_if.snap_valid_out !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold_after: got valid=%0b state=%0d want 0,0", snap_if.snap_valid_out, dbg_state);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [31:0]  word;
    int           lat;
    int           stall;
    for (int n = 0; n < 16; n++) begin
      word = $urandom;
      load_rf(word);
      exp_q.push_back({1'b0, word});
      snap_if.snap_ready_in = 1'b0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      wait_valid(lat);
      n_assert++;
      if (lat !== 3) begin
        n_fail++;
        $display("FAIL rand_latency_%0d: got %0d want 3", n, lat);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) tick();
      snap_if.snap_ready_in = 1'b1;
      pop_exp(e);
      n_assert++;
      if (snap_if.snap_valid_out !== 1'b1 || {snap_if.torn_out, snap_if.snap_out} !== e) begin
        n_fail++;
        $display("FAIL rand_word_%0d: got valid=%0b word=%h want 1,%h",
                 n, snap_if.snap_valid_out, {snap_if.torn_out, snap_if.snap_out}, e);
      end
      tick();
    end
  endtask

`ifdef SNAP_SEQ_EN
  task automatic test_seq_wrap();
    logic [W-1:0] e;
    int           lat;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_rf(32'h2468_ACE0);
    snap_if.snap_ready_in = 1'b1;
    for (int n = 0; n < 257; n++) begin
      exp_q.push_back({1'b0, 32'h2468_ACE0});
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      wait_valid(lat);
      n_assert++;
      if (snap_if.seq_out !== 8'(n)) begin
        n_fail++;
        $display("FAIL seq_value_%0d: got %0d want %0d", n, snap_if.seq_out, n % 256);
      end
      pop_exp(e);
      n_assert++;
      if ({snap_if.torn_out, snap_if.snap_out} !== e) begin
        n_fail++;
        $display("FAIL seq_word_%0d: got %h want %h", n, {snap_if.torn_out, snap_if.snap_out}, e);
      end
      tick();
    end
    n_assert++;
    if (snap_if.seq_out !== 8'd1) begin
      n_fail++;
      $display("FAIL seq_wrap_final: got %0d want 1", snap_if.seq_out);
    end
  endtask
`endif

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clean();
    test_backpressure();
    test_write_first();
    test_write_last();
    test_retry_exhaust();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SNAP_SEQ_EN
    test_seq_wrap();
`endif
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
